sobel_window_gen: RTL and testbench
===================================

# sobel_window_gen

Streaming 3x3 neighbourhood generator that sits directly upstream of the Sobel edge stage: it takes one 8-bit grey pixel per `pix_valid` strobe from the UART receive path in raster order and presents a correctly aligned 3x3 window, plus its centre coordinates, to the gradient computation. Two on-chip line buffers hold the previous two image rows, so every interior pixel gets a true spatial neighbourhood. The block replaces the flat 9-byte shift register and has no backpressure: it accepts every strobe.

## Interface
- `IMG_WIDTH`, default 64: pixels per row; must be ≥ 3.
- `IMG_HEIGHT`, default 48: rows per frame; must be ≥ 3.
- `PIX_W`, default 8: pixel width in bits.
- `clk`, in, 1: clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `sof`, in, 1: start of frame; restarts the raster position.
- `pix_valid`, in, 1: `pix_data` is valid this cycle.
- `pix_data`, in, PIX_W: incoming pixel.
- `win_valid`, out, 1: `win` holds a complete window this cycle.
- `win`, out, 9*PIX_W: window, with tap k at `win[k*PIX_W +: PIX_W]`.
  - k = 3*row + col.
  - Row 0 is the oldest row (r-2); column 0 is the leftmost (c-2).
- `win_row`, out, $clog2(IMG_HEIGHT): row of the window centre.
- `win_col`, out, $clog2(IMG_WIDTH): column of the window centre.
- `frame_done`, out, 1: one-cycle pulse after the last pixel of a frame.

## Operation
- **Position counters:** column counter `c` (0..IMG_WIDTH-1) and row counter `r` (0..IMG_HEIGHT-1). They advance only on an accepted pixel (`pix_valid`=1).
  - `c` wraps to 0 and increments `r` at the end of each row.
  - Both counters wrap to 0 after pixel (IMG_HEIGHT-1, IMG_WIDTH-1).
- **Line buffers:** `lb0` holds row r-2 and `lb1` holds row r-1, each IMG_WIDTH deep. On an accepted pixel p at (r, c):
  - Read taps `t0 = lb0[c]` and `t1 = lb1[c]` as the old contents (read-before-write).
  - Write `lb0[c] <= t1` and `lb1[c] <= p`.
- **Window shift**, on an accepted pixel:
  - Each window row shifts left by one: `w[3i] <= w[3i+1]` and `w[3i+1] <= w[3i+2]`.
  - New rightmost column: `w[2] <= t0`, `w[5] <= t1`, `w[8] <= p`.
- **Valid gating:** `win_valid` is 1 for the cycle after an accepted pixel with r ≥ 2 and c ≥ 2; otherwise it is 0.
  - Windows that straddle a row boundary (c < 2) are suppressed.
  - Windows during the first two rows are suppressed.
  - Each frame emits exactly (IMG_WIDTH-2)*(IMG_HEIGHT-2) windows.
- **Centre coordinates:** `win_row` = r-1 and `win_col` = c-1, registered with `win`. They hold their value when `win_valid`=0.
- **`frame_done`:** asserted in the same cycle as the `win_valid` for pixel (IMG_HEIGHT-1, IMG_WIDTH-1).
- **`sof` with `pix_valid`:** the pixel is treated as (0,0) and the counters continue from there.
- **`sof` without `pix_valid`:** the counters clear to 0 and nothing else changes.
- **Line buffer contents:** never cleared. Stale data is harmless because of the valid gating.
- **Input gaps:** any number of idle cycles between pixels is allowed. All state, including `win`, holds during idle cycles.

## Timing
- Latency is 1 cycle: pixel accepted at edge N → `win` and `win_valid` registered at edge N+1.
- Throughput is one pixel per cycle sustained, with no stalls.
- `win_valid` and `frame_done` are single-cycle pulses per accepted pixel. They are never asserted in a cycle that follows a cycle with no accepted pixel.
- Reset values: every output is 0, including `win`, `win_row` and `win_col`. Counters and window registers are also 0. Line buffer RAM is not reset.
- Reset asserted mid-frame: outputs go to 0 immediately (asynchronously). After release, the first accepted pixel is (0,0).
- `sof` and the row wrap in the same cycle: `sof` wins and the pixel is (0,0).

## Structure
- Package `img_pkg` holds:
  - `PIX_W`.
  - `typedef logic [PIX_W-1:0] pix_t`.
  - The window index constants (`WIN_TAPS` = 9).
  - A helper function for tap slicing, shared with the Sobel stage.
- Sub-module `line_buffer`: IMG_WIDTH x (2*PIX_W) memory with one shared address, asynchronous read of the old data, and a synchronous write enable. It stores `lb0` and `lb1` side by side so the block uses one instance.
- The top-level module holds the counters, the window registers and the output registers.

## Test plan
All scenarios use `IMG_WIDTH`=4, `IMG_HEIGHT`=4, and pixel value = 16*r + c.
1. **Reset:** assert `rst_n`=0 with random inputs → all outputs 0. After release, with no `pix_valid`, outputs stay 0.
2. **Continuous frame:** `sof` on the first pixel, then 16 pixels back-to-back → exactly 4 `win_valid` pulses.
   - First window: centre (1,1), `win` = {0,1,2,16,17,18,32,33,34}.
   - Last window: centre (2,2), `win` = {17,18,19,33,34,35,49,50,51}, with `frame_done` in the same cycle.
3. **Random gaps:** the same frame with random 0–5 idle cycles between pixels → identical window sequence, each window 1 cycle after its pixel, and no extra pulses.
4. **`sof` mid-frame:** 6 pixels, then a new frame with `sof` → 4 windows, identical to scenario 2, and no window from the aborted frame.
5. **Back-to-back frames:** two consecutive frames with no gap → 8 windows total, second frame identical to the first, and no window mixing rows 3 and 0.
6. **Reset mid-frame:** `rst_n` pulsed after 9 pixels, then a full frame → outputs 0 during reset, then scenario 2 results.

Source files
------------

// File: rtl/img_pkg.sv
// Shared pixel/window types for the Sobel front end.
// Tap k of a window sits at bits [k*PIX_W +: PIX_W].
package img_pkg;

  localparam int PIX_W    = 8;
  localparam int WIN_TAPS = 9;
  localparam int WIN_W    = WIN_TAPS * PIX_W;

  typedef logic [PIX_W-1:0] pix_t;
  typedef logic [WIN_W-1:0] win_t;

  function automatic pix_t win_tap(
    input win_t w,
    input int   k
  );
    return w[k*PIX_W +: PIX_W];
  endfunction

endpackage

// File: rtl/sobel_window_gen_if.sv
// Pixel-in / window-out bundle of the 3x3 window generator.
// master drives pixels; slave is the window generator.
interface sobel_window_gen_if #(
  parameter int IMG_WIDTH  = 64,
  parameter int IMG_HEIGHT = 48,
  parameter int PIX_W      = 8
);
  import img_pkg::*;

  logic                          sof;
  logic                          pix_valid;
  logic [PIX_W-1:0]              pix_data;
  logic                          win_valid;
  logic [WIN_TAPS*PIX_W-1:0]     win;
  logic [$clog2(IMG_HEIGHT)-1:0] win_row;
  logic [$clog2(IMG_WIDTH)-1:0]  win_col;
  logic                          frame_done;

  modport master (
    output sof, pix_valid, pix_data,
    input  win_valid, win, win_row,
    input  win_col, frame_done
  );

  modport slave (
    input  sof, pix_valid, pix_data,
    output win_valid, win, win_row,
    output win_col, frame_done
  );

endinterface

// File: rtl/line_buffer.sv
// Single-port line memory: async read of old data, sync write.
// Holds {row r-2, row r-1} side by side at one column address.
module line_buffer #(
  parameter int DEPTH = 64,
  parameter int DW    = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [DW-1:0]            wr_data,
  output logic [DW-1:0]            rd_data
);

  logic [DW-1:0] mem [DEPTH];

  assign rd_data = mem[addr];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wr_data;
  end

endmodule

// File: rtl/sobel_window_gen.sv
// Streaming 3x3 window generator with two line buffers.
// Windows are emitted one cycle after the pixel completing them.
module sobel_window_gen #(
  parameter int IMG_WIDTH  = 64,
  parameter int IMG_HEIGHT = 48,
  parameter int PIX_W      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  sobel_window_gen_if.slave bus
);
  import img_pkg::*;

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] C_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] R_LAST = RW'(IMG_HEIGHT - 1);
  localparam int WW = WIN_TAPS * PIX_W;

  logic [CW-1:0]      c_q, c_d, cur_c;
  logic [RW-1:0]      r_q, r_d, cur_r;
  logic [2*PIX_W-1:0] lb_rd;
  logic [PIX_W-1:0]   t0, t1;
  logic               in_win;
  logic               last_pix;

  logic [WW-1:0]      w_q;
  logic               valid_q;
  logic               done_q;
  logic [RW-1:0]      row_q;
  logic [CW-1:0]      col_q;

  // sof forces the current pixel to (0,0), overriding any row wrap
  always_comb begin
    cur_c    = bus.sof ? '0 : c_q;
    cur_r    = bus.sof ? '0 : r_q;
    in_win   = (cur_r >= RW'(2)) && (cur_c >= CW'(2));
    last_pix = (cur_r == R_LAST) && (cur_c == C_LAST);
    c_d      = c_q;
    r_d      = r_q;
    if (bus.pix_valid) begin
      if (cur_c == C_LAST) begin
        c_d = '0;
        r_d = (cur_r == R_LAST) ? '0 : cur_r + 1'b1;
      end else begin
        c_d = cur_c + 1'b1;
        r_d = cur_r;
      end
    end else if (bus.sof) begin
      c_d = '0;
      r_d = '0;
    end
  end

  assign {t0, t1} = lb_rd;

  line_buffer #(
    .DEPTH (IMG_WIDTH),
    .DW    (2*PIX_W)
  ) u_lb (
    .clk     (clk),
    .we      (bus.pix_valid),
    .addr    (cur_c),
    .wr_data ({t1, bus.pix_data}),
    .rd_data (lb_rd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_q     <= '0;
      r_q     <= '0;
      w_q     <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      c_q     <= c_d;
      r_q     <= r_d;
      valid_q <= bus.pix_valid && in_win;
      done_q  <= bus.pix_valid && last_pix;
      if (bus.pix_valid) begin
        for (int i = 0; i < 3; i++) begin
          w_q[(3*i)*PIX_W +: PIX_W] <=
            w_q[(3*i+1)*PIX_W +: PIX_W];
          w_q[(3*i+1)*PIX_W +: PIX_W] <=
            w_q[(3*i+2)*PIX_W +: PIX_W];
        end
        w_q[2*PIX_W +: PIX_W] <= t0;
        w_q[5*PIX_W +: PIX_W] <= t1;
        w_q[8*PIX_W +: PIX_W] <= bus.pix_data;
      end
      if (bus.pix_valid && in_win) begin
        row_q <= cur_r - 1'b1;
        col_q <= cur_c - 1'b1;
      end
    end
  end

  assign bus.win_valid  = valid_q;
  assign bus.frame_done = done_q;
  assign bus.win        = w_q;
  assign bus.win_row    = row_q;
  assign bus.win_col    = col_q;

endmodule

// File: tb/tb_sobel_window_gen.sv
// Randomised bench for sobel_window_gen on a 4x4 image.
// Reference keeps the received frame as a 2D array.
module tb_sobel_window_gen;
  import img_pkg::*;

  localparam int W = 4;
  localparam int H = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sobel_window_gen_if #(
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H),
    .PIX_W      (PIX_W)
  ) bus ();

  sobel_window_gen #(
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H),
    .PIX_W      (PIX_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  int   img [H][W];
  int   mr, mc;
  int   erow, ecol;
  int   dcnt;
  win_t fw, lw;
  bit   got_first;

  task automatic check(
    input string        tag,
    input logic [127:0] obs,
    input logic [127:0] exp
  );
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h",
               tag, obs, exp);
    end
  endtask

  function automatic win_t ref_win(int r, int c);
    win_t e = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        e[(3*i+j)*PIX_W +: PIX_W] =
          PIX_W'(img[r-2+i][c-2+j]);
    return e;
  endfunction

  task automatic model_reset();
    mr = 0; mc = 0; erow = 0; ecol = 0;
  endtask

  task automatic chk_zero(input string tag);
    check({tag, ".valid"}, bus.win_valid, 0);
    check({tag, ".done"}, bus.frame_done, 0);
    check({tag, ".win"}, bus.win, 0);
    check({tag, ".row"}, bus.win_row, 0);
    check({tag, ".col"}, bus.win_col, 0);
  endtask

  task automatic send(input bit s, input int p);
    bit v, fd;
    @(negedge clk);
    bus.sof       = s;
    bus.pix_valid = 1'b1;
    bus.pix_data  = PIX_W'(p);
    @(posedge clk);
    #1;
    if (s) begin mr = 0; mc = 0; end
    img[mr][mc] = p & 8'hff;
    v  = (mr >= 2) && (mc >= 2);
    fd = (mr == H-1) && (mc == W-1);
    check("valid", bus.win_valid, v);
    check("done", bus.frame_done, fd);
    if (v) begin
      erow = mr - 1;
      ecol = mc - 1;
      check("win", bus.win, ref_win(mr, mc));
    end
    check("row", bus.win_row, erow);
    check("col", bus.win_col, ecol);
    if (bus.win_valid) begin
      dcnt++;
      if (!got_first) fw = bus.win;
      got_first = 1'b1;
      lw = bus.win;
    end
    if (mc == W-1) begin
      mc = 0;
      mr = (mr == H-1) ? 0 : mr + 1;
    end else begin
      mc++;
    end
  endtask

  task automatic idle(input bit s);
    @(negedge clk);
    bus.sof       = s;
    bus.pix_valid = 1'b0;
    bus.pix_data  = PIX_W'($urandom);
    @(posedge clk);
    #1;
    if (s) begin mr = 0; mc = 0; end
    check("idle.valid", bus.win_valid, 0);
    check("idle.done", bus.frame_done, 0);
    check("idle.row", bus.win_row, erow);
    check("idle.col", bus.win_col, ecol);
    if (bus.win_valid) dcnt++;
  endtask

  task automatic frame(
    input string tag,
    input bit    gaps,
    input bit    rnd,
    input bit    use_sof
  );
    int d0 = dcnt;
    int p;
    got_first = 1'b0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        if (gaps)
          repeat ($urandom_range(5)) idle(1'b0);
        p = rnd ? int'($urandom_range(255))
                : 16*r + c;
        send(use_sof && r == 0 && c == 0, p);
      end
    check({tag, ".count"}, dcnt - d0,
          (W-2)*(H-2));
  endtask

  task automatic partial(input int n);
    for (int i = 0; i < n; i++)
      send(i == 0, 16*(i/W) + i%W);
  endtask

  task automatic do_reset(input string tag);
    #2;
    rst_n = 1'b0;
    bus.pix_valid = 1'b0;
    bus.sof = 1'b0;
    #1;
    chk_zero(tag);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  win_t first_exp, last_exp;

  initial begin
    first_exp = {8'd34, 8'd33, 8'd32, 8'd18,
                 8'd17, 8'd16, 8'd2, 8'd1, 8'd0};
    last_exp  = {8'd51, 8'd50, 8'd49, 8'd35,
                 8'd34, 8'd33, 8'd19, 8'd18, 8'd17};
    dcnt = 0;
    model_reset();
    bus.sof = 1'b0;
    bus.pix_valid = 1'b0;
    bus.pix_data = '0;

    // reset with random inputs toggling
    repeat (4) begin
      @(negedge clk);
      bus.sof       = 1'($urandom);
      bus.pix_valid = 1'($urandom);
      bus.pix_data  = PIX_W'($urandom);
      #1;
      chk_zero("rst");
    end
    bus.sof = 1'b0;
    bus.pix_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) idle(1'b0);
    chk_zero("post_rst");

    frame("cont", 1'b0, 1'b0, 1'b1);
    check("cont.first", fw, first_exp);
    check("cont.last", lw, last_exp);
    check("cont.ctr", win_tap(fw, 4), 17);

    frame("gaps", 1'b1, 1'b0, 1'b1);
    check("gaps.first", fw, first_exp);
    check("gaps.last", lw, last_exp);

    partial(6);
    frame("sofmid", 1'b0, 1'b0, 1'b1);
    check("sofmid.first", fw, first_exp);

    frame("b2b_a", 1'b0, 1'b0, 1'b1);
    frame("b2b_b", 1'b0, 1'b0, 1'b0);
    check("b2b.first", fw, first_exp);
    check("b2b.last", lw, last_exp);

    partial(9);
    do_reset("midrst");
    frame("midrst", 1'b0, 1'b0, 1'b1);
    check("midrst.last", lw, last_exp);

    partial(5);
    idle(1'b1);
    frame("sofidle", 1'b0, 1'b0, 1'b0);
    check("sofidle.first", fw, first_exp);

    for (int k = 0; k < 4; k++)
      frame("rnd", 1'(k[0]), 1'b1, 1'(k < 2));

    repeat (3) idle(1'b0);
    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
